// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter_pkg: ALU op codes and arbiter FSM encodings        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package alu_share_arbiter_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 3'b000;  // a + b + ci
  localparam alu_op_t ALU_SUB   = 3'b001;  // a + ~b + ci, co is the not-borrow
  localparam alu_op_t ALU_AND   = 3'b010;
  localparam alu_op_t ALU_OR    = 3'b011;
  localparam alu_op_t ALU_XOR   = 3'b100;
  localparam alu_op_t ALU_PASSB = 3'b101;
  localparam alu_op_t ALU_SHL   = 3'b110;  // ci shifts in at the lsb
  localparam alu_op_t ALU_SHR   = 3'b111;  // ci shifts in at the msb

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter_alu: combinational WIDTH-bit ALU with carry       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = '0;
    y     = '0;
    co    = 1'b0;
    case (op)
      ALU_ADD: begin
        w_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        {co, y} = w_sum;
      end
      ALU_SUB: begin
        w_sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ci};
        {co, y} = w_sum;
      end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_PASSB: y = b;
      ALU_SHL: begin
        y  = {a[WIDTH-2:0], ci};
        co = a[WIDTH-1];
      end
      ALU_SHR: begin
        y  = {ci, a[WIDTH-1:1]};
        co = a[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_share_arbiter: round-robin sharing of one ALU by two requesters |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_ci,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_co,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt0,
  output logic [CNT_W-1:0]   done_cnt1
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic             r_prio;
  logic             r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ci;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_co;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_win;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_co;

  // A lone valid requester wins outright; prio only breaks ties.
  assign w_win     = (req_valid == 2'b11) ? r_prio : req_valid[1];
  assign w_accept  = (r_state == IDLE) && (|req_valid);
  assign req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_co     = r_co;
  assign busy       = (r_state != IDLE);
  assign done_cnt0  = r_cnt0;
  assign done_cnt1  = r_cnt1;

  alu_share_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op (r_op),
    .a  (r_a),
    .b  (r_b),
    .ci (r_ci),
    .y  (w_alu_y),
    .co (w_alu_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_id        <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ci        <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_result    <= '0;
      r_co        <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id    <= w_win;
            r_prio  <= ~w_win;
            r_op    <= w_win ? req_op[5:3] : req_op[2:0];
            r_a     <= w_win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            r_b     <= w_win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            r_ci    <= w_win ? req_ci[1] : req_ci[0];
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result    <= w_alu_y;
          r_co        <= w_alu_co;
          r_rsp_valid <= r_id ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the owner's ready can retire the response.
          if (rsp_ready[r_id]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
            if (!r_id && (r_cnt0 != c_cnt_max)) r_cnt0 <= r_cnt0 + c_cnt_one;
            if (r_id && (r_cnt1 != c_cnt_max))  r_cnt1 <= r_cnt1 + c_cnt_one;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
